// File: rtl/alu_pkg.sv
// Shared opcode map, control width and sequencer state encoding for the ALU op sequencer.
package alu_pkg;

    localparam int OP_ADD   = 0;
    localparam int OP_SUB   = 1;
    localparam int OP_MUL   = 2;
    localparam int OP_DIV   = 3;
    localparam int OP_SHR   = 4;
    localparam int OP_SHL   = 5;
    localparam int OP_ROR   = 6;
    localparam int OP_ROL   = 7;
    localparam int OP_AND   = 8;
    localparam int OP_OR    = 9;
    localparam int OP_NEG   = 10;
    localparam int OP_NOT   = 11;
    localparam int OP_COUNT = 12;

    localparam int SIG_COUNT = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Down-counter width for the longest op; at least one bit even if both latencies are 1.
    function automatic int cnt_width(input int mul_cycles, input int div_cycles);
        int longest;
        longest = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
        return ($clog2(longest) > 0) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational opcode decode: one-hot ALU control, EXEC latency minus one, and invalid flag.
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter int SIG_COUNT  = alu_pkg::SIG_COUNT,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8,
    parameter int CNT_W      = 3
) (
    input  logic [3:0]           opcode,
    output logic [SIG_COUNT-1:0] ctrl,
    output logic [CNT_W-1:0]     lat_m1,
    output logic                 invalid
);

    always_comb begin
        ctrl    = '0;
        lat_m1  = '0;
        invalid = 1'b0;
        if (int'(opcode) >= OP_COUNT) begin
            invalid = 1'b1;
        end else begin
            ctrl = SIG_COUNT'(1) << opcode;
            case (int'(opcode))
                OP_MUL:  lat_m1 = CNT_W'(MUL_CYCLES - 1);
                OP_DIV:  lat_m1 = CNT_W'(DIV_CYCLES - 1);
                default: lat_m1 = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation per request: latches operands, holds the one-hot control
// for the op's cycle budget, then captures the double-width result.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for a request; req_ready high while clear is high
//   ST_EXEC | alu_ctrl driven; cnt counts down, result captured at cnt==0
//   ST_DONE | one-cycle done pulse; err set for an invalid opcode
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int BITS       = 32,
    parameter int SIG_COUNT  = alu_pkg::SIG_COUNT,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           opcode,
    input  logic [BITS-1:0]      x_in,
    input  logic [BITS-1:0]      y_in,
    output logic [SIG_COUNT-1:0] alu_ctrl,
    output logic [BITS-1:0]      alu_x,
    output logic [BITS-1:0]      alu_y,
    input  logic [2*BITS-1:0]    alu_result,
    output logic [BITS-1:0]      z_hi,
    output logic [BITS-1:0]      z_lo,
    output logic                 done,
    output logic                 err,
    output logic                 busy
);

    localparam int CNT_W = cnt_width(MUL_CYCLES, DIV_CYCLES);

    state_t                state;
    state_t                state_nxt;
    logic [SIG_COUNT-1:0]  ctrl_q;
    logic [CNT_W-1:0]      cnt;
    logic                  err_q;
    logic                  accept;

    logic [SIG_COUNT-1:0]  dec_ctrl;
    logic [CNT_W-1:0]      dec_lat_m1;
    logic                  dec_invalid;

    alu_op_decoder #(
        .SIG_COUNT  (SIG_COUNT),
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_decoder (
        .opcode  (opcode),
        .ctrl    (dec_ctrl),
        .lat_m1  (dec_lat_m1),
        .invalid (dec_invalid)
    );

    assign accept = req_valid && req_ready;

    always_ff @(posedge clock) begin
        if (!clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = dec_invalid ? ST_DONE : ST_EXEC;
            ST_EXEC: if (cnt == '0) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE) && clear;
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        err       = (state == ST_DONE) && err_q;
        alu_ctrl  = (state == ST_EXEC) ? ctrl_q : '0;
    end

    // Operands and control are latched once per accept; the result only at the final EXEC edge.
    always_ff @(posedge clock) begin
        if (!clear) begin
            alu_x  <= '0;
            alu_y  <= '0;
            z_hi   <= '0;
            z_lo   <= '0;
            ctrl_q <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                alu_x  <= x_in;
                alu_y  <= y_in;
                ctrl_q <= dec_ctrl;
                cnt    <= dec_lat_m1;
                err_q  <= dec_invalid;
            end
            if (state == ST_EXEC) begin
                if (cnt == '0) begin
                    {z_hi, z_lo} <= alu_result;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed literal scenarios followed by randomized traffic,
// every cycle compared against a transaction-age reference model.
module tb_alu_op_sequencer;

    localparam int BITS  = 32;
    localparam int SIG   = 12;
    localparam int MUL_C = 4;
    localparam int DIV_C = 8;

    logic              clock = 1'b0;
    logic              clear;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        opcode;
    logic [BITS-1:0]   x_in, y_in;
    logic [SIG-1:0]    alu_ctrl;
    logic [BITS-1:0]   alu_x, alu_y;
    logic [2*BITS-1:0] alu_result;
    logic [BITS-1:0]   z_hi, z_lo;
    logic              done, err, busy;

    logic              alu_mode;
    logic [63:0]       noise;

    int n_cmp    = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int done_cnt = 0;
    bit check_en = 1'b0;
    int acc_q[$];

    // Reference model: a request is tracked by its age in cycles since the accept edge.
    bit          m_active = 1'b0;
    int          m_age    = 0;
    int          m_lat    = 0;
    int          m_end    = 0;
    logic [3:0]  m_op     = 4'd0;
    logic [31:0] m_x      = 32'd0;
    logic [31:0] m_y      = 32'd0;
    logic [63:0] m_z      = 64'd0;

    always #5 clock = ~clock;

    alu_op_sequencer #(
        .BITS       (BITS),
        .SIG_COUNT  (SIG),
        .MUL_CYCLES (MUL_C),
        .DIV_CYCLES (DIV_C)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .opcode     (opcode),
        .x_in       (x_in),
        .y_in       (y_in),
        .alu_ctrl   (alu_ctrl),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_result (alu_result),
        .z_hi       (z_hi),
        .z_lo       (z_lo),
        .done       (done),
        .err        (err),
        .busy       (busy)
    );

    function automatic logic [63:0] ref_alu(input logic [11:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        logic [63:0] t;
        r = 32'd0;
        t = 64'd0;
        case (c)
            12'h001: r = a + b;
            12'h002: r = a - b;
            12'h004: return {32'd0, a} * {32'd0, b};
            12'h008: r = (b == 32'd0) ? 32'd0 : a / b;
            12'h010: r = a >> b[4:0];
            12'h020: r = a << b[4:0];
            12'h040: begin t = {a, a} >> b[4:0]; r = t[31:0];  end
            12'h080: begin t = {a, a} << b[4:0]; r = t[63:32]; end
            12'h100: r = a & b;
            12'h200: r = a | b;
            12'h400: r = -a;
            12'h800: r = ~a;
            default: return 64'hBAD0_BAD0_BAD0_BAD0;
        endcase
        return {32'd0, r};
    endfunction

    always_comb alu_result = alu_mode ? noise : ref_alu(alu_ctrl, alu_x, alu_y);

    function automatic int lat_of(input logic [3:0] op);
        if (op == 4'd2) return MUL_C;
        if (op == 4'd3) return DIV_C;
        return 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: advance the model at the edge, compare outputs 1ns later, return at negedge.
    task automatic step();
        logic [11:0] exp_ctrl;
        bit          exp_done;
        @(posedge clock);
        cyc++;
        if (!clear) begin
            m_active = 1'b0;
            m_x      = 32'd0;
            m_y      = 32'd0;
            m_z      = 64'd0;
        end else if (m_active) begin
            if (m_op < 4'd12 && m_age == m_lat) m_z = alu_result;
            if (m_age == m_end) m_active = 1'b0;
            else m_age++;
        end else if (req_valid) begin
            m_active = 1'b1;
            m_age    = 1;
            m_op     = opcode;
            m_x      = x_in;
            m_y      = y_in;
            m_lat    = lat_of(opcode);
            m_end    = (opcode < 4'd12) ? m_lat + 1 : 1;
            acc_q.push_back(cyc);
        end
        #1;
        if (done) done_cnt++;
        if (check_en) begin
            exp_done = m_active && (m_age == m_end);
            exp_ctrl = (m_active && m_op < 4'd12 && m_age <= m_lat) ? (12'h001 << m_op) : 12'h000;
            check("req_ready", 64'(req_ready), 64'(!m_active && clear));
            check("busy",      64'(busy),      64'(m_active));
            check("done",      64'(done),      64'(exp_done));
            check("err",       64'(err),       64'(exp_done && m_op >= 4'd12));
            check("alu_ctrl",  64'(alu_ctrl),  64'(exp_ctrl));
            check("alu_x",     64'(alu_x),     64'(m_x));
            check("alu_y",     64'(alu_y),     64'(m_y));
            check("z",         {z_hi, z_lo},   m_z);
            check("ctrl_onehot0", 64'($onehot0(alu_ctrl)), 64'd1);
            check("ready_busy_excl", 64'(req_ready && busy), 64'd0);
        end
        @(negedge clock);
    endtask

    // Issue one request (called at a negedge) and wait for its done pulse.
    task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int nexec, output logic [11:0] lctrl);
        int guard;
        lat   = 0;
        nexec = 0;
        lctrl = 12'h000;
        req_valid = 1'b1;
        opcode    = op;
        x_in      = x;
        y_in      = y;
        guard = 0;
        while (!req_ready && guard < 20) begin
            step();
            guard++;
        end
        step();
        req_valid = 1'b0;
        x_in      = 32'hFFFF_FFFF;
        y_in      = 32'hFFFF_FFFF;
        lat = 1;
        while (!done && lat < 50) begin
            if (alu_ctrl != 12'h000) begin
                nexec++;
                lctrl = alu_ctrl;
            end
            step();
            lat++;
        end
        if (lat >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL op_timeout: no done within %0d cycles for opcode %0d", lat, op);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat, nexec, d0, n0, guard;
        logic [11:0] lctrl;

        clear     = 1'b0;
        req_valid = 1'b0;
        opcode    = 4'd0;
        x_in      = 32'd0;
        y_in      = 32'd0;
        noise     = 64'd0;
        alu_mode  = 1'b0;
        repeat (3) step();
        check_en = 1'b1;
        check("rst_ctrl",  64'(alu_ctrl), 64'd0);
        check("rst_busy",  64'(busy),     64'd0);
        check("rst_done",  64'(done),     64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_z",     {z_hi, z_lo},  64'd0);
        check("rst_x",     64'(alu_x),    64'd0);

        clear = 1'b1;
        step();
        check("idle_ready", 64'(req_ready), 64'd1);

        // add 5+7
        do_op(4'd0, 32'd5, 32'd7, lat, nexec, lctrl);
        check("add_latency", 64'(lat),   64'd2);
        check("add_exec",    64'(nexec), 64'd1);
        check("add_ctrl",    64'(lctrl), 64'h001);
        check("add_z_lo",    64'(z_lo),  64'd12);
        check("add_z_hi",    64'(z_hi),  64'd0);
        check("add_err",     64'(err),   64'd0);

        // multiply 2^16 * 2^16
        do_op(4'd2, 32'h0001_0000, 32'h0001_0000, lat, nexec, lctrl);
        check("mul_latency", 64'(lat),   64'd5);
        check("mul_exec",    64'(nexec), 64'd4);
        check("mul_ctrl",    64'(lctrl), 64'h004);
        check("mul_z",       {z_hi, z_lo}, 64'h1_0000_0000);

        // invalid opcode leaves the result untouched
        do_op(4'd13, 32'd3, 32'd4, lat, nexec, lctrl);
        check("inv_latency", 64'(lat),   64'd1);
        check("inv_exec",    64'(nexec), 64'd0);
        check("inv_err",     64'(err),   64'd1);
        check("inv_z",       {z_hi, z_lo}, 64'h1_0000_0000);

        // divide aborted by clear in its third EXEC cycle
        step();
        req_valid = 1'b1;
        opcode    = 4'd3;
        x_in      = 32'd100;
        y_in      = 32'd7;
        guard = 0;
        while (!req_ready && guard < 20) begin
            step();
            guard++;
        end
        step();
        req_valid = 1'b0;
        repeat (2) step();
        check("abort_exec_ctrl", 64'(alu_ctrl), 64'h008);
        d0 = done_cnt;
        clear = 1'b0;
        step();
        check("abort_ctrl",  64'(alu_ctrl),   64'd0);
        check("abort_busy",  64'(busy),       64'd0);
        check("abort_done",  64'(done),       64'd0);
        check("abort_z",     {z_hi, z_lo},    64'd0);
        check("abort_xy",    {alu_x, alu_y},  64'd0);
        clear = 1'b1;
        repeat (10) step();
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);

        // three back-to-back subtracts with req_valid held high
        d0 = done_cnt;
        n0 = acc_q.size();
        req_valid = 1'b1;
        opcode    = 4'd1;
        x_in      = 32'd9;
        y_in      = 32'd4;
        guard = 0;
        while (acc_q.size() < n0 + 3 && guard < 40) begin
            step();
            guard++;
        end
        req_valid = 1'b0;
        check("b2b_accepts", 64'(acc_q.size() - n0), 64'd3);
        if (acc_q.size() >= n0 + 3) begin
            check("b2b_gap1", 64'(acc_q[n0+1] - acc_q[n0]),   64'd3);
            check("b2b_gap2", 64'(acc_q[n0+2] - acc_q[n0+1]), 64'd3);
        end
        repeat (4) step();
        check("b2b_dones", 64'(done_cnt - d0), 64'd3);
        check("b2b_z_lo",  64'(z_lo), 64'd5);

        // randomized traffic with a noisy result bus and occasional resets
        alu_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            noise     = {$urandom, $urandom};
            req_valid = ($urandom_range(0, 2) == 0);
            opcode    = 4'($urandom_range(0, 15));
            x_in      = $urandom;
            y_in      = $urandom;
            clear     = ($urandom_range(0, 199) != 0);
            step();
        end
        clear     = 1'b1;
        req_valid = 1'b0;
        repeat (15) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
